// File: rtl/serial_subtractor_if.sv
// Handshake/result bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             b_out;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, b_in,
`ifdef SERIAL_SUB_OVF_EN
      input  ovf,
`endif
      input  busy, done, diff, b_out
   );

   modport slave (
      input  start, a, b, b_in,
`ifdef SERIAL_SUB_OVF_EN
      output ovf,
`endif
      output busy, done, diff, b_out
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - b_in, LSB first, one bit per clock.
// A single full-subtractor cell is fed from the operand shift registers and a borrow FF;
// its difference bit shifts into the result register from the MSB side.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; operands captured when start is seen
//   S_SHIFT | one bit per clock through the cell, busy=1
//   S_DONE  | one-cycle done pulse; diff/b_out/ovf just updated
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   serial_subtractor_if.slave bus
);

   localparam int               CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             borrow;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] diff_q;
   logic             b_out_q;
   logic             cell_d;
   logic             cell_bout;
   logic             last_bit;

   // Full-subtractor cell on the current LSBs and the running borrow
   assign cell_d    = a_sr[0] ^ b_sr[0] ^ borrow;
   assign cell_bout = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
   assign last_bit  = (state == S_SHIFT) && (cnt == LAST);

   // Control FSM plus operand/borrow/result shifting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_sr   <= bus.a;
                  b_sr   <= bus.b;
                  borrow <= bus.b_in;
                  res_sr <= '0;
                  cnt    <= '0;
                  state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= {cell_d, res_sr[WIDTH-1:1]};
               borrow <= cell_bout;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Visible results only change on entry to DONE, so partial sums never leak out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q  <= '0;
         b_out_q <= 1'b0;
      end else if (last_bit) begin
         diff_q  <= {cell_d, res_sr[WIDTH-1:1]};
         b_out_q <= cell_bout;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb;
   logic b_msb;
   logic ovf_q;

   // Operand sign bits are kept aside because the shift registers consume them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf_q <= 1'b0;
      end else if (state == S_IDLE && bus.start) begin
         a_msb <= bus.a[WIDTH-1];
         b_msb <= bus.b[WIDTH-1];
      end else if (last_bit) begin
         ovf_q <= (a_msb != b_msb) && (cell_d != a_msb);
      end
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.busy  = (state == S_SHIFT);
   assign bus.done  = (state == S_DONE);
   assign bus.diff  = diff_q;
   assign bus.b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, exhaustive 3-bit sweep,
// randomized operands against an integer-arithmetic model, and hand-written corner sequences.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) bus8();
   serial_subtractor_if #(.WIDTH(3)) bus3();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_subtractor #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   int n_pass = 0;
   int n_chk  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: plain integer arithmetic
   function automatic int model_diff(input int a, input int b, input int bin, input int w);
      return (a - b - bin) & ((1 << w) - 1);
   endfunction

   function automatic int model_bout(input int a, input int b, input int bin);
      return (a < b + bin) ? 1 : 0;
   endfunction

   function automatic int model_ovf8(input int a, input int b, input int bin);
      int sa, sb, r;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      r  = sa - sb - bin;
      return (r < -128 || r > 127) ? 1 : 0;
   endfunction

   // One operation on the 8-bit instance; called at posedge+1 with the DUT in IDLE
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      output logic [7:0] d, output logic bo, output int lat,
                      output int busy_n, output bit stable, output bit done_once);
      logic [7:0] prev_d;
      prev_d = bus8.diff;
      bus8.a = a; bus8.b = b; bus8.b_in = bin; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.b_in = 1'($urandom);
      lat = 0; busy_n = 0; stable = 1'b1;
      while (!bus8.done && lat < 40) begin
         if (bus8.busy) busy_n++;
         if (bus8.diff !== prev_d) stable = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      d  = bus8.diff;
      bo = bus8.b_out;
      @(posedge clk); #1;
      done_once = !bus8.done;
   endtask

   task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic bin,
                      output logic [2:0] d, output logic bo, output int lat);
      bus3.a = a; bus3.b = b; bus3.b_in = bin; bus3.start = 1'b1;
      @(posedge clk); #1;
      bus3.start = 1'b0;
      lat = 0;
      while (!bus3.done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      d  = bus3.diff;
      bo = bus3.b_out;
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t       vt[6];
      logic [7:0] d;
      logic [2:0] d3;
      logic       bo;
      int         lat, busy_n, pulses;
      bit         stable, done_once;
      int         ra, rb, rbin;

      vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
      vt[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
      vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      vt[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vt[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
      vt[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};

      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.b_in = 1'b0;
      bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.b_in = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset busy",  bus8.busy,  0);
      chk("reset done",  bus8.done,  0);
      chk("reset diff",  bus8.diff,  0);
      chk("reset b_out", bus8.b_out, 0);
`ifdef SERIAL_SUB_OVF_EN
      chk("reset ovf",   bus8.ovf,   0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table
      foreach (vt[i]) begin
         op8(vt[i].a, vt[i].b, vt[i].bin, d, bo, lat, busy_n, stable, done_once);
         chk($sformatf("vec%0d diff", i), d, vt[i].d);
         chk($sformatf("vec%0d b_out", i), bo, vt[i].bo);
         chk($sformatf("vec%0d latency", i), lat, 8);
         chk($sformatf("vec%0d busy cycles", i), busy_n, 8);
         chk($sformatf("vec%0d diff held", i), stable, 1);
         chk($sformatf("vec%0d done single", i), done_once, 1);
`ifdef SERIAL_SUB_OVF_EN
         chk($sformatf("vec%0d ovf", i), bus8.ovf, model_ovf8(vt[i].a, vt[i].b, vt[i].bin));
`endif
      end

`ifdef SERIAL_SUB_OVF_EN
      op8(8'h80, 8'h01, 1'b0, d, bo, lat, busy_n, stable, done_once);
      chk("ovf 80-01", bus8.ovf, 1);
      op8(8'h05, 8'h03, 1'b0, d, bo, lat, busy_n, stable, done_once);
      chk("ovf 05-03", bus8.ovf, 0);
`endif

      // Exhaustive 3-bit sweep
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            for (int bin = 0; bin < 2; bin++) begin
               op3(3'(a), 3'(b), 1'(bin), d3, bo, lat);
               chk($sformatf("w3 %0d-%0d-%0d diff", a, b, bin), d3, model_diff(a, b, bin, 3));
               chk($sformatf("w3 %0d-%0d-%0d b_out", a, b, bin), bo, model_bout(a, b, bin));
               chk($sformatf("w3 %0d-%0d-%0d latency", a, b, bin), lat, 3);
            end

      // Randomized operands
      for (int i = 0; i < 150; i++) begin
         ra = int'($urandom_range(255)); rb = int'($urandom_range(255)); rbin = int'($urandom_range(1));
         op8(8'(ra), 8'(rb), 1'(rbin), d, bo, lat, busy_n, stable, done_once);
         chk($sformatf("rand %0h-%0h-%0d diff", ra, rb, rbin), d, model_diff(ra, rb, rbin, 8));
         chk($sformatf("rand %0h-%0h-%0d b_out", ra, rb, rbin), bo, model_bout(ra, rb, rbin));
         chk($sformatf("rand %0h-%0h-%0d latency", ra, rb, rbin), lat, 8);
`ifdef SERIAL_SUB_OVF_EN
         chk($sformatf("rand %0h-%0h-%0d ovf", ra, rb, rbin), bus8.ovf, model_ovf8(ra, rb, rbin));
`endif
      end

      // Second start pulse mid-operation is ignored
      bus8.a = 8'h10; bus8.b = 8'h01; bus8.b_in = 1'b0; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      bus8.a = 8'hFF; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus8.done) pulses++;
         @(posedge clk); #1;
      end
      chk("mid-start diff", bus8.diff, 8'h0F);
      chk("mid-start pulses", pulses, 1);

      // Reset mid-operation aborts with no done pulse
      bus8.a = 8'hAA; bus8.b = 8'h55; bus8.b_in = 1'b0; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("abort busy",  bus8.busy,  0);
      chk("abort done",  bus8.done,  0);
      chk("abort diff",  bus8.diff,  0);
      chk("abort b_out", bus8.b_out, 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus8.done) pulses++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus8.done) pulses++;
      end
      chk("abort no done", pulses, 0);
      op8(8'h09, 8'h04, 1'b0, d, bo, lat, busy_n, stable, done_once);
      chk("after abort diff", d, 8'h05);
      chk("after abort b_out", bo, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
